cp0_reg: RTL
============

Name: cp0_reg

Overview:
- System coprocessor 0 register file for the 5-stage MIPS core.
- Sits at the writeback end of the pipeline and is the consumer of the wb_cp0_reg_we / wb_cp0_reg_waddr / wb_cp0_reg_wdata write port produced by the MEM/WB stage register.
- Holds Count, Compare, Status, Cause, EPC, PRId and Config.
- Runs the Count/Compare timer and records exception state for the exception/flush controller.

Parameters:
- PRID_VALUE, 32'h00480102, read-only value of PRId (reg 15).
- CONFIG_VALUE, 32'h00008000, read-only value of Config (reg 16); BE=1.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- we  in  1  CP0 write enable from the WB stage
- waddr  in  5  CP0 write register number
- wdata  in  32  CP0 write data
- raddr  in  5  CP0 read register number (mfc0)
- int_i  in  6  external hardware interrupt lines, level-sensitive
- excepttype_i  in  32  exception code from the MEM stage; 0 = none
- current_inst_addr_i  in  32  PC of the excepting instruction
- is_in_delayslot_i  in  1  excepting instruction is in a delay slot
- data_o  out  32  combinational read data for raddr
- count_o, compare_o, status_o, cause_o, epc_o, config_o, prid_o  out  32 each  direct register views
- timer_int_o  out  1  timer interrupt request, registered

Behaviour:
- Reset values:
  - count 0, compare 0, cause 0, epc 0, timer_int_o 0.
  - status 32'h10000000 (CU0=1).
  - config CONFIG_VALUE, prid PRID_VALUE.
- Every non-reset cycle:
  - count <= count+1; wraps 32'hFFFFFFFF -> 0.
  - cause[15:10] <= int_i.
- Timer:
  - If compare != 0 and count == compare, timer_int_o <= 1 on the next edge.
  - It stays 1 until a write to Compare or reset.
  - cause[30] (TI) mirrors timer_int_o.
- Software write (we=1), updates on the next edge:
  - 9 (Count): count <= wdata; replaces that cycle's increment.
  - 11 (Compare): compare <= wdata and timer_int_o <= 0. The clear wins over a same-cycle match.
  - 12 (Status): status <= wdata.
  - 13 (Cause): only IP[1:0] (bits 9:8), WP (22) and IV (23) are written; other bits unchanged.
  - 14 (EPC): epc <= wdata.
  - 15, 16 and all other addresses: ignored.
- Exception handling:
  - Evaluated in the same edge, after the software write. Exception updates win on any conflicting field.
  - Codes requiring EPC capture:
    - 32'h1 interrupt, ExcCode 0
    - 32'h8 syscall, ExcCode 8
    - 32'ha reserved instruction, ExcCode 10
    - 32'hc overflow, ExcCode 12
    - 32'hd trap, ExcCode 13
  - For these codes:
    - If status[1] (EXL) == 0: epc <= current_inst_addr_i - 4 and cause[31] (BD) <= 1 when is_in_delayslot_i, else epc <= current_inst_addr_i and BD <= 0.
    - In all cases: status[1] <= 1 and cause[6:2] <= ExcCode.
    - If EXL was already 1, epc and BD are unchanged.
  - 32'he (eret): status[1] <= 0 only.
  - Any other nonzero code: no state change.
- Read path:
  - data_o is combinational from the stored register for raddr 9, 11, 12, 13, 14, 15, 16; 0 otherwise.
  - No internal forwarding unless CP0_WR_BYPASS_EN is defined.
- rst asserted mid-operation: all state returns to reset values on that edge, overriding write, exception and timer.

Optional Feature:
- Macro: CP0_WR_BYPASS_EN.
- Defined: if we=1 and waddr==raddr in the same cycle, data_o returns the value the register will hold after the write.
  - For Cause, this is the masked merge of wdata with stored bits.
  - For 15, 16 and other read-only or unknown addresses, data_o is unchanged by the bypass.
- Undefined: data_o reflects stored state only; the pipeline forwards externally.

Test Plan:
- Reset, then 3 idle cycles -> count_o=3, status_o=32'h10000000, prid_o=PRID_VALUE, data_o at raddr=16 equals CONFIG_VALUE, timer_int_o=0.
- Write Count=5, then Compare=10 -> timer_int_o rises on the edge after count_o==10 and remains 1. A later Compare write clears it on the next edge.
- Write Count=32'hFFFFFFFF -> next cycle count_o=0. Compare=0 never raises timer_int_o.
- excepttype_i=32'h8, current_inst_addr_i=32'h100, is_in_delayslot_i=1, EXL=0 -> epc_o=32'hFC, cause[31]=1, cause[6:2]=8, status[1]=1. A following excepttype_i=32'ha at 32'h200 -> epc_o stays 32'hFC, ExcCode=10.
- excepttype_i=32'he -> status[1]=0. Same cycle, write Status=32'h0000FF03 and excepttype_i=32'h1 -> status_o=32'h0000FF03 (EXL forced 1).
- Write Cause=32'hFFFFFFFF with int_i=6'b101010 -> cause_o[15:10]=6'b101010, bits 23,22,9,8 =1, BD/ExcCode unchanged.
  - With CP0_WR_BYPASS_EN defined, a same-cycle read of raddr=13 shows the merged value.

Source files
------------

// File: rtl/cp0_reg.sv
// cp0_reg: MIPS coprocessor 0 register file (Count/Compare timer, Status, Cause, EPC, PRId, Config).
// Optional macro CP0_WR_BYPASS_EN forwards a same-cycle software write onto data_o.
`default_nettype none

module cp0_reg #(
  parameter logic [31:0] PRID_VALUE   = 32'h00480102,
  parameter logic [31:0] CONFIG_VALUE = 32'h00008000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr,
  input  logic [5:0]  int_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] current_inst_addr_i,
  input  logic        is_in_delayslot_i,
  output logic [31:0] data_o,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic [31:0] epc_o,
  output logic [31:0] config_o,
  output logic [31:0] prid_o,
  output logic        timer_int_o
);

  localparam logic [4:0]  REG_COUNT   = 5'd9;
  localparam logic [4:0]  REG_COMPARE = 5'd11;
  localparam logic [4:0]  REG_STATUS  = 5'd12;
  localparam logic [4:0]  REG_CAUSE   = 5'd13;
  localparam logic [4:0]  REG_EPC     = 5'd14;
  localparam logic [4:0]  REG_PRID    = 5'd15;
  localparam logic [4:0]  REG_CONFIG  = 5'd16;
  // Software-writable Cause fields: IV, WP, IP[1:0]
  localparam logic [31:0] CAUSE_WR_MASK = 32'h00C00300;
  localparam logic [31:0] STATUS_RESET  = 32'h10000000;

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] status_q, status_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        timer_q, timer_d;

  logic [31:0] cause_wr;
  logic        exc_epc;
  logic [4:0]  exc_code;

  assign cause_wr = (cause_q & ~CAUSE_WR_MASK) | (wdata & CAUSE_WR_MASK);

  always_comb begin
    exc_epc  = 1'b1;
    exc_code = 5'd0;
    case (excepttype_i)
      32'h0000_0001: exc_code = 5'd0;
      32'h0000_0008: exc_code = 5'd8;
      32'h0000_000a: exc_code = 5'd10;
      32'h0000_000c: exc_code = 5'd12;
      32'h0000_000d: exc_code = 5'd13;
      default:       exc_epc  = 1'b0;
    endcase
  end

  always_comb begin
    count_d   = count_q + 32'd1;
    compare_d = compare_q;
    status_d  = status_q;
    cause_d   = cause_q;
    epc_d     = epc_q;
    timer_d   = timer_q | ((compare_q != 32'd0) && (count_q == compare_q));
    cause_d[15:10] = int_i;

    if (we) begin
      case (waddr)
        REG_COUNT:   count_d = wdata;
        REG_COMPARE: begin
          compare_d = wdata;
          timer_d   = 1'b0;
        end
        REG_STATUS:  status_d = wdata;
        REG_CAUSE:   cause_d = (cause_d & ~CAUSE_WR_MASK) | (wdata & CAUSE_WR_MASK);
        REG_EPC:     epc_d = wdata;
        default:     ;
      endcase
    end

    // Exception state is applied on top of the software write, using the post-write EXL.
    if (exc_epc) begin
      if (!status_d[1]) begin
        epc_d       = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
        cause_d[31] = is_in_delayslot_i;
      end
      status_d[1]  = 1'b1;
      cause_d[6:2] = exc_code;
    end else if (excepttype_i == 32'h0000_000e) begin
      status_d[1] = 1'b0;
    end

    cause_d[30] = timer_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      status_q  <= STATUS_RESET;
      cause_q   <= 32'd0;
      epc_q     <= 32'd0;
      timer_q   <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      epc_q     <= epc_d;
      timer_q   <= timer_d;
    end
  end

  logic [31:0] rd_stored;

  always_comb begin
    case (raddr)
      REG_COUNT:   rd_stored = count_q;
      REG_COMPARE: rd_stored = compare_q;
      REG_STATUS:  rd_stored = status_q;
      REG_CAUSE:   rd_stored = cause_q;
      REG_EPC:     rd_stored = epc_q;
      REG_PRID:    rd_stored = PRID_VALUE;
      REG_CONFIG:  rd_stored = CONFIG_VALUE;
      default:     rd_stored = 32'd0;
    endcase
  end

`ifdef CP0_WR_BYPASS_EN
  always_comb begin
    data_o = rd_stored;
    if (we && (waddr == raddr)) begin
      case (raddr)
        REG_COUNT, REG_COMPARE, REG_STATUS, REG_EPC: data_o = wdata;
        REG_CAUSE: data_o = cause_wr;
        default:   ;
      endcase
    end
  end
`else
  assign data_o = rd_stored;
`endif

  assign count_o     = count_q;
  assign compare_o   = compare_q;
  assign status_o    = status_q;
  assign cause_o     = cause_q;
  assign epc_o       = epc_q;
  assign config_o    = CONFIG_VALUE;
  assign prid_o      = PRID_VALUE;
  assign timer_int_o = timer_q;

endmodule

`default_nettype wire
